gpu_register_bank: RTL and testbench

- Parametrised, double-buffered register bank between the HPS Avalon-MM bridge and the triangle rasteriser.
- Software writes vertex and background-colour shadow registers, then sets CSR.GO.
- GO commits all shadows atomically to the rasteriser-facing outputs, issues a one-cycle start pulse, and tracks busy/done until the rasteriser reports completion.
- The CSR is readable from the bus at full width and accessible bit-wise from hardware.

---
 rtl/gpu_regbank_pkg.sv | 33 +++
 rtl/regbank_csr.sv | 78 +++++++
 rtl/gpu_register_bank.sv | 182 ++++++++++++++++++
 tb/tb_gpu_register_bank.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_regbank_pkg.sv
// Shared constants, address-map helpers and FSM state type for gpu_register_bank.
package gpu_regbank_pkg;

    // CSR bit positions; bits CSR_GP_LSB and above are general-purpose read/write.
    localparam int unsigned CSR_GO     = 0;
    localparam int unsigned CSR_BUSY   = 1;
    localparam int unsigned CSR_DONE   = 2;
    localparam int unsigned CSR_ERR    = 3;
    localparam int unsigned CSR_IE     = 4;
    localparam int unsigned CSR_GP_LSB = 5;

    // STATUS word layout: [STATUS_NV_W-1:0] = NUM_VERTEX, [STATUS_NV_W] = FSM state.
    localparam int unsigned STATUS_NV_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Word addresses following the vertex shadows.
    function automatic int unsigned addr_back_colour(input int unsigned num_vertex);
        return num_vertex;
    endfunction

    function automatic int unsigned addr_csr(input int unsigned num_vertex);
        return num_vertex + 1;
    endfunction

    function automatic int unsigned addr_status(input int unsigned num_vertex);
        return num_vertex + 2;
    endfunction

endpackage

// File: rtl/regbank_csr.sv
// Control/status register: bus write with self-clearing GO and W1C DONE/ERR,
// FSM status events, and a single-bit hardware port that overrides the bus write.
// Optional IE bit is enabled by GPU_REGBANK_IRQ_EN.
module regbank_csr
    import gpu_regbank_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_we,
    input  logic [DATA_W-1:0]         bus_wdata,
    input  logic                      set_busy,
    input  logic                      done_evt,
    input  logic                      set_err,
    input  logic [$clog2(DATA_W)-1:0] hw_addr,
    input  logic                      hw_load,
    input  logic                      hw_bit,
    output logic [DATA_W-1:0]         csr,
    output logic                      hw_bit_out
);

    localparam int unsigned BIT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] csr_q, csr_d;
    logic              hw_writable;
    logic              ie_ok;

    // IE is only a real bit when the interrupt feature is built in.
`ifdef GPU_REGBANK_IRQ_EN
    assign ie_ok = 1'b1;
    logic unused_wdata;
    assign unused_wdata = ^{bus_wdata[CSR_GO], bus_wdata[CSR_BUSY]};
`else
    assign ie_ok = (hw_addr != BIT_W'(CSR_IE));
    logic unused_wdata;
    assign unused_wdata = ^{bus_wdata[CSR_GO], bus_wdata[CSR_BUSY], bus_wdata[CSR_IE]};
`endif

    // Hardware may not touch GO or BUSY; those are owned by the commit FSM.
    assign hw_writable = hw_load
                      && (hw_addr != BIT_W'(CSR_GO))
                      && (hw_addr != BIT_W'(CSR_BUSY))
                      && (32'(hw_addr) < DATA_W)
                      && ie_ok;

    // Next CSR value: bus write, then FSM events, then hardware bit override.
    always_comb begin
        csr_d = csr_q;
        if (bus_we) begin
            csr_d[DATA_W-1:CSR_GP_LSB] = bus_wdata[DATA_W-1:CSR_GP_LSB];
`ifdef GPU_REGBANK_IRQ_EN
            csr_d[CSR_IE] = bus_wdata[CSR_IE];
`endif
            if (bus_wdata[CSR_DONE]) csr_d[CSR_DONE] = 1'b0;
            if (bus_wdata[CSR_ERR])  csr_d[CSR_ERR]  = 1'b0;
        end
        if (set_busy) csr_d[CSR_BUSY] = 1'b1;
        if (done_evt) begin
            csr_d[CSR_BUSY] = 1'b0;
            csr_d[CSR_DONE] = 1'b1;
        end
        if (set_err) csr_d[CSR_ERR] = 1'b1;
        if (hw_writable) csr_d[hw_addr] = hw_bit;
        // GO is a trigger, never stored.
        csr_d[CSR_GO] = 1'b0;
    end

    // CSR state register.
    always_ff @(posedge clk) begin
        if (reset) csr_q <= '0;
        else       csr_q <= csr_d;
    end

    assign csr        = csr_q;
    assign hw_bit_out = csr_q[hw_addr];

endmodule

// File: rtl/gpu_register_bank.sv
// Double-buffered register bank between the Avalon-MM bridge and the rasteriser.
// Shadow registers are committed atomically on CSR.GO; a two-state FSM tracks busy/done.
// Optional feature macro: GPU_REGBANK_IRQ_EN (registered irq = DONE & IE).
module gpu_register_bank
    import gpu_regbank_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned NUM_VERTEX = 3,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write,
    input  logic                         read,
    input  logic [ADDR_W-1:0]            address,
    input  logic [DATA_W-1:0]            writedata,
    output logic [DATA_W-1:0]            readdata,
    output logic                         readdatavalid,
    input  logic [$clog2(DATA_W)-1:0]    control_bit_address,
    input  logic                         control_bit_load,
    input  logic                         control_bit_in,
    output logic                         control_bit_out,
    output logic [NUM_VERTEX*DATA_W-1:0] vertex_out,
    output logic [DATA_W-1:0]            back_colour_out,
    output logic [DATA_W-1:0]            control_status_out,
    output logic                         start,
    input  logic                         done_in,
    output logic                         irq
);

    localparam logic [ADDR_W-1:0] ADDR_BACK   = ADDR_W'(addr_back_colour(NUM_VERTEX));
    localparam logic [ADDR_W-1:0] ADDR_CSR    = ADDR_W'(addr_csr(NUM_VERTEX));
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(addr_status(NUM_VERTEX));

    logic [DATA_W-1:0]            vtx_shadow_q [NUM_VERTEX];
    logic [DATA_W-1:0]            back_shadow_q;
    logic [NUM_VERTEX*DATA_W-1:0] vertex_q;
    logic [DATA_W-1:0]            back_colour_q;
    logic                         start_q;
    logic [DATA_W-1:0]            readdata_q;
    logic                         readdatavalid_q;
    logic [DATA_W-1:0]            rd_data;
    logic [DATA_W-1:0]            status_word;
    logic [DATA_W-1:0]            csr;

    state_e state_q, state_d;
    logic   bus_csr_we;
    logic   go_write;
    logic   commit;
    logic   done_evt;
    logic   set_err;

    assign bus_csr_we = write && (address == ADDR_CSR);
    assign go_write   = bus_csr_we && writedata[CSR_GO];

    // FSM next state and commit/event decode.
    always_comb begin
        state_d  = state_q;
        commit   = 1'b0;
        done_evt = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go_write) begin
                    commit  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A second GO while the rasteriser is still working is a software error.
                if (go_write) set_err = 1'b1;
                if (done_in) begin
                    done_evt = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Shadow registers, writable at any time including during RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VERTEX; i++) vtx_shadow_q[i] <= '0;
            back_shadow_q <= '0;
        end else if (write) begin
            for (int i = 0; i < NUM_VERTEX; i++) begin
                if (address == ADDR_W'(i)) vtx_shadow_q[i] <= writedata;
            end
            if (address == ADDR_BACK) back_shadow_q <= writedata;
        end
    end

    // Committed outputs and the one-cycle start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            vertex_q      <= '0;
            back_colour_q <= '0;
            start_q       <= 1'b0;
        end else begin
            start_q <= commit;
            if (commit) begin
                for (int i = 0; i < NUM_VERTEX; i++) begin
                    vertex_q[i*DATA_W +: DATA_W] <= vtx_shadow_q[i];
                end
                back_colour_q <= back_shadow_q;
            end
        end
    end

    // STATUS word: NUM_VERTEX in the low nibble, FSM state just above it.
    always_comb begin
        status_word                        = '0;
        status_word[STATUS_NV_W-1:0]       = STATUS_NV_W'(NUM_VERTEX);
        status_word[STATUS_NV_W]           = (state_q == ST_RUN);
    end

    // Read mux over pre-write values so a simultaneous write is not visible.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_VERTEX; i++) begin
            if (address == ADDR_W'(i)) rd_data = vtx_shadow_q[i];
        end
        if (address == ADDR_BACK)   rd_data = back_shadow_q;
        if (address == ADDR_CSR)    rd_data = csr;
        if (address == ADDR_STATUS) rd_data = status_word;
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            readdatavalid_q <= read;
            if (read) readdata_q <= rd_data;
        end
    end

    regbank_csr #(
        .DATA_W (DATA_W)
    ) u_csr (
        .clk        (clk),
        .reset      (reset),
        .bus_we     (bus_csr_we),
        .bus_wdata  (writedata),
        .set_busy   (commit),
        .done_evt   (done_evt),
        .set_err    (set_err),
        .hw_addr    (control_bit_address),
        .hw_load    (control_bit_load),
        .hw_bit     (control_bit_in),
        .csr        (csr),
        .hw_bit_out (control_bit_out)
    );

`ifdef GPU_REGBANK_IRQ_EN
    logic irq_q;
    // Interrupt follows DONE & IE one cycle later.
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= csr[CSR_DONE] & csr[CSR_IE];
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign readdata           = readdata_q;
    assign readdatavalid      = readdatavalid_q;
    assign vertex_out         = vertex_q;
    assign back_colour_out    = back_colour_q;
    assign control_status_out = csr;
    assign start              = start_q;

endmodule

// File: tb/tb_gpu_register_bank.sv
// Self-checking bench for gpu_register_bank (DATA_W=64, NUM_VERTEX=3, ADDR_W=4).
module tb_gpu_register_bank;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         write = 1'b0;
    logic         read = 1'b0;
    logic [3:0]   address = '0;
    logic [63:0]  writedata = '0;
    logic [63:0]  readdata;
    logic         readdatavalid;
    logic [5:0]   control_bit_address = '0;
    logic         control_bit_load = 1'b0;
    logic         control_bit_in = 1'b0;
    logic         control_bit_out;
    logic [191:0] vertex_out;
    logic [63:0]  back_colour_out;
    logic [63:0]  control_status_out;
    logic         start;
    logic         done_in = 1'b0;
    logic         irq;

    int tests = 0;
    int fails = 0;

    // Reference model state, kept as plain named fields.
    logic [63:0] m_shadow [3];
    logic [63:0] m_back;
    logic [63:0] m_vert [3];
    logic [63:0] m_col;
    logic [63:0] m_gp;      // general-purpose CSR bits (5 and up only)
    logic        m_busy, m_done, m_err, m_ie;
    logic        m_run;
    logic        m_start;
    logic [63:0] m_rdata;
    logic        m_rvalid;
    logic        m_irq;

    always #5 clk = ~clk;

    gpu_register_bank #(
        .DATA_W     (64),
        .NUM_VERTEX (3),
        .ADDR_W     (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .write               (write),
        .read                (read),
        .address             (address),
        .writedata           (writedata),
        .readdata            (readdata),
        .readdatavalid       (readdatavalid),
        .control_bit_address (control_bit_address),
        .control_bit_load    (control_bit_load),
        .control_bit_in      (control_bit_in),
        .control_bit_out     (control_bit_out),
        .vertex_out          (vertex_out),
        .back_colour_out     (back_colour_out),
        .control_status_out  (control_status_out),
        .start               (start),
        .done_in             (done_in),
        .irq                 (irq)
    );

    function automatic logic [63:0] m_csr();
        logic [63:0] v;
        v = m_gp;
        v[1] = m_busy;
        v[2] = m_done;
        v[3] = m_err;
        v[4] = m_ie;
        return v;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] a);
        case (a)
            4'd0, 4'd1, 4'd2: return m_shadow[a];
            4'd3:             return m_back;
            4'd4:             return m_csr();
            4'd5:             return {59'b0, m_run, 4'd3};
            default:          return 64'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_shadow[i] = '0;
            m_vert[i]   = '0;
        end
        m_back = '0; m_col = '0; m_gp = '0;
        m_busy = 0; m_done = 0; m_err = 0; m_ie = 0;
        m_run = 0; m_start = 0; m_rdata = '0; m_rvalid = 0; m_irq = 0;
    endtask

    // Apply the current inputs for one clock to both model and DUT, then compare.
    task automatic step();
        logic        go;
        logic        nrun;
        logic        irq_n;
        logic [63:0] csr_now;
        int          ha;
        if (reset) begin
            model_reset();
        end else begin
`ifdef GPU_REGBANK_IRQ_EN
            irq_n = m_done & m_ie;
`else
            irq_n = 1'b0;
`endif
            if (read) m_rdata = m_read(address);
            m_rvalid = read;
            go      = write && (address == 4'd4) && writedata[0];
            m_start = go && !m_run;
            if (m_start) begin
                m_vert = m_shadow;
                m_col  = m_back;
            end
            nrun = m_run;
            if (write) begin
                if (address < 4'd3) m_shadow[address] = writedata;
                else if (address == 4'd3) m_back = writedata;
                else if (address == 4'd4) begin
                    m_gp = writedata & ~64'h1f;
`ifdef GPU_REGBANK_IRQ_EN
                    m_ie = writedata[4];
`endif
                    if (writedata[2]) m_done = 0;
                    if (writedata[3]) m_err = 0;
                end
            end
            if (go && !m_run) begin m_busy = 1; nrun = 1; end
            if (go && m_run) m_err = 1;
            if (m_run && done_in) begin m_busy = 0; m_done = 1; nrun = 0; end
            ha = int'(control_bit_address);
            if (control_bit_load && ha != 0 && ha != 1) begin
                if (ha == 2) m_done = control_bit_in;
                else if (ha == 3) m_err = control_bit_in;
                else if (ha == 4) begin
`ifdef GPU_REGBANK_IRQ_EN
                    m_ie = control_bit_in;
`endif
                end else m_gp[ha] = control_bit_in;
            end
            m_run = nrun;
            m_irq = irq_n;
        end
        @(posedge clk);
        #1;
        csr_now = m_csr();
        check("readdatavalid", 192'(readdatavalid), 192'(m_rvalid));
        check("readdata", 192'(readdata), 192'(m_rdata));
        check("vertex_out", vertex_out, {m_vert[2], m_vert[1], m_vert[0]});
        check("back_colour_out", 192'(back_colour_out), 192'(m_col));
        check("control_status_out", 192'(control_status_out), 192'(csr_now));
        check("start", 192'(start), 192'(m_start));
        check("irq", 192'(irq), 192'(m_irq));
        check("control_bit_out", 192'(control_bit_out), 192'(csr_now[control_bit_address]));
        write = 0; read = 0; control_bit_load = 0; done_in = 0; reset = 0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [63:0] d);
        write = 1; address = a; writedata = d;
        step();
    endtask

    task automatic bus_read(input logic [3:0] a);
        read = 1; address = a;
        step();
    endtask

    initial begin
        model_reset();
        // Reset and read every address.
        reset = 1; step();
        reset = 1; step();
        for (int a = 0; a < 16; a++) bus_read(4'(a));
        bus_read(4'd5);
        check("status_idle", 192'(readdata), 192'd3);

        // Load shadows; committed outputs must not move yet.
        bus_write(4'd0, 64'h11);
        bus_write(4'd1, 64'h22);
        bus_write(4'd2, 64'h33);
        bus_write(4'd3, 64'hFF);
        check("vertex_before_go", vertex_out, 192'd0);
        bus_write(4'd4, 64'h1);
        check("vertex_after_go", vertex_out, {64'h33, 64'h22, 64'h11});
        check("start_pulse", 192'(start), 192'd1);
        step();
        check("start_one_cycle", 192'(start), 192'd0);

        // GO during RUN is an error and does not commit.
        bus_write(4'd0, 64'hAA);
        bus_write(4'd4, 64'h1);
        check("err_set", 192'(control_status_out[3]), 192'd1);
        bus_read(4'd5);
        check("status_run", 192'(readdata), 192'h13);
        bus_read(4'd0);
        done_in = 1; step();
        check("done_set", 192'(control_status_out[3:0]), 192'hC);
        bus_write(4'd4, 64'h8);

        // Bus and hardware hit bit 7 in the same cycle: hardware wins.
        control_bit_address = 6'd7; control_bit_load = 1; control_bit_in = 0;
        bus_write(4'd4, 64'h80);
        check("hw_overrides_bus", 192'(control_status_out[7]), 192'd0);
        control_bit_address = 6'd1; control_bit_load = 1; control_bit_in = 1;
        step();
        check("busy_protected", 192'(control_status_out[1]), 192'd0);

        // Interrupt flow (irq stays 0 when the feature is not built in).
        bus_write(4'd4, 64'h10);
        bus_write(4'd4, 64'h11);
        step();
        done_in = 1; step();
        step();
        step();
        bus_write(4'd4, 64'h14);
        step();
        check("irq_after_w1c", 192'(irq), 192'd0);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            write     = ($urandom_range(0, 1) == 1);
            read      = ($urandom_range(0, 1) == 1);
            address   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) address = 4'd4;
            writedata = {$urandom, $urandom};
            done_in   = ($urandom_range(0, 7) == 0);
            control_bit_address = 6'($urandom_range(0, 63));
            control_bit_load    = ($urandom_range(0, 3) == 0);
            control_bit_in      = 1'($urandom_range(0, 1));
            step();
        end

        // Reset mid-RUN aborts; a late done_in is ignored.
        control_bit_address = 6'd2;
        bus_write(4'd1, 64'h5555);
        bus_write(4'd4, 64'h1);
        step();
        reset = 1; step();
        check("reset_vertex", vertex_out, 192'd0);
        check("reset_csr", 192'(control_status_out), 192'd0);
        done_in = 1; step();
        check("late_done_ignored", 192'(control_status_out[2]), 192'd0);
        bus_read(4'd5);
        check("status_after_reset", 192'(readdata), 192'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
